// File: rtl/pc_fetch.sv
// Program counter, opcode slicer, zero flag and RUN/HALT state for the single-cycle CPU.
// Optional return stack for call/return opcodes is enabled by defining PC_STACK_EN.
module pc_fetch #(
    parameter int PC_W        = 10,
    parameter int INSTR_W     = 16,
    parameter int RESET_PC    = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [INSTR_W-1:0] instr,
    input  logic               s_inc,
    input  logic               wez,
    input  logic               alu_zero,
    output logic [PC_W-1:0]    pc,
    output logic [5:0]         opcode,
    output logic               z,
`ifdef PC_STACK_EN
    output logic               sp_empty,
`endif
    output logic               halted
);

    localparam logic [5:0] OP_HALT = 6'b111111;

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;
    logic            z_q;
    logic            halted_q;
    logic            advance;

    assign opcode  = instr[INSTR_W-1 -: 6];
    assign target  = instr[PC_W-1:0];
    assign pc_inc  = pc_q + 1'b1;
    assign advance = en && !halted_q;

`ifdef PC_STACK_EN
    localparam logic [5:0] OP_CALL = 6'b001010;
    localparam logic [5:0] OP_RET  = 6'b001011;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [PC_W-1:0]  stk_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic             is_call;
    logic             is_ret;
    logic             stk_full;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] push_idx;

    assign is_call  = (opcode == OP_CALL);
    assign is_ret   = (opcode == OP_RET);
    assign stk_full = (sp_q == SP_W'(STACK_DEPTH));
    assign top_idx  = IDX_W'(sp_q - 1'b1);
    assign push_idx = IDX_W'(sp_q);
    assign sp_empty = (sp_q == '0);

    always_comb begin
        pc_d = s_inc ? pc_inc : target;
        if (is_call) begin
            pc_d = target;
        end else if (is_ret) begin
            // Return with an empty stack behaves as a plain increment.
            pc_d = sp_empty ? pc_inc : stk_q[top_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sp_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
        end else if (advance && opcode != OP_HALT) begin
            if (is_call) begin
                // Full stack drops the oldest entry so the newest return address survives.
                if (stk_full) begin
                    for (int i = 0; i < STACK_DEPTH - 1; i++) stk_q[i] <= stk_q[i+1];
                    stk_q[STACK_DEPTH-1] <= pc_inc;
                end else begin
                    stk_q[push_idx] <= pc_inc;
                    sp_q            <= sp_q + 1'b1;
                end
            end else if (is_ret && !sp_empty) begin
                sp_q <= sp_q - 1'b1;
            end
        end
    end
`else
    always_comb begin
        pc_d = s_inc ? pc_inc : target;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= PC_W'(RESET_PC);
            z_q      <= 1'b0;
            halted_q <= 1'b0;
        end else if (advance) begin
            if (opcode == OP_HALT) begin
                halted_q <= 1'b1;
            end else begin
                pc_q <= pc_d;
            end
            if (wez) begin
                z_q <= alu_zero;
            end
        end
    end

    assign pc     = pc_q;
    assign z      = z_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios followed by random stimulus against a queue-based model.
module tb_pc_fetch;

    localparam int PC_W        = 10;
    localparam int INSTR_W     = 16;
    localparam int RESET_PC    = 0;
    localparam int STACK_DEPTH = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               en = 1'b0;
    logic [INSTR_W-1:0] instr = '0;
    logic               s_inc = 1'b0;
    logic               wez = 1'b0;
    logic               alu_zero = 1'b0;
    logic [PC_W-1:0]    pc;
    logic [5:0]         opcode;
    logic               z;
    logic               halted;
`ifdef PC_STACK_EN
    logic               sp_empty;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: plain integers and a queue standing in for the return stack.
    int unsigned m_pc = 0;
    bit          m_z = 0;
    bit          m_halted = 0;
    int unsigned m_stack[$];

    pc_fetch #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .instr(instr), .s_inc(s_inc), .wez(wez),
        .alu_zero(alu_zero), .pc(pc), .opcode(opcode), .z(z),
`ifdef PC_STACK_EN
        .sp_empty(sp_empty),
`endif
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_edge();
        int unsigned op  = (instr >> 10) & 6'h3f;
        int unsigned tgt = instr % (1 << PC_W);
        int unsigned inc = (m_pc + 1) % (1 << PC_W);
        if (!reset) begin
            m_pc = RESET_PC; m_z = 0; m_halted = 0;
            m_stack.delete();
            return;
        end
        if (!en || m_halted) return;
        if (op == 63) begin
            m_halted = 1;
        end else begin
`ifdef PC_STACK_EN
            if (op == 10) begin
                if (m_stack.size() == STACK_DEPTH) void'(m_stack.pop_front());
                m_stack.push_back(inc);
                m_pc = tgt;
            end else if (op == 11) begin
                m_pc = (m_stack.size() == 0) ? inc : m_stack.pop_back();
            end else
`endif
            m_pc = s_inc ? inc : tgt;
        end
        if (wez) m_z = alu_zero;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".z"}, z, m_z);
        chk({tag, ".halted"}, halted, m_halted);
        chk({tag, ".opcode"}, opcode, (instr >> 10) & 6'h3f);
`ifdef PC_STACK_EN
        chk({tag, ".sp_empty"}, sp_empty, m_stack.size() == 0);
`endif
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic jump_to(input int unsigned a);
        en = 1; s_inc = 0; wez = 0; instr = {6'b001000, 10'(a)};
        step("jump");
        chk("jump_target", pc, a);
    endtask

    initial begin
        // Reset held for two edges with a halt word on the bus.
        reset = 0; en = 1; instr = 16'hFFFF; s_inc = 1; wez = 1; alu_zero = 1;
        step("rst0");
        step("rst1");
        chk("rst_pc", pc, 0);
        reset = 1; instr = 16'h0000; s_inc = 1; wez = 0;
        for (int i = 1; i <= 3; i++) begin
            step("inc");
            chk("inc_seq", pc, i);
        end

        jump_to(5);
        instr = {6'b001000, 10'd200}; s_inc = 0;
        step("jmp200");
        chk("jmp200_pc", pc, 200);
        jump_to(5);
        instr = {6'b001000, 10'd200}; s_inc = 1;
        step("seq6");
        chk("seq6_pc", pc, 6);

        wez = 1; alu_zero = 1; step("z_set");   chk("z_set", z, 1);
        wez = 0; alu_zero = 0; step("z_hold");  chk("z_hold", z, 1);
        wez = 1; alu_zero = 0; step("z_clr");   chk("z_clr", z, 0);

        jump_to(1023);
        instr = 16'h0000; s_inc = 1; wez = 0;
        step("wrap");
        chk("wrap_pc", pc, 0);
        en = 0; s_inc = 1; wez = 1; alu_zero = 1;
        for (int i = 0; i < 3; i++) begin
            instr = 16'($urandom);
            step("stall");
            chk("stall_pc", pc, 0);
            chk("stall_z", z, 0);
        end

        jump_to(7);
        instr = 16'hFC00; wez = 0;
        step("halt");
        chk("halt_flag", halted, 1);
        for (int i = 0; i < 10; i++) begin
            instr = 16'($urandom); s_inc = 0; en = 1'($urandom); wez = 1; alu_zero = 1;
            step("halted");
            chk("halted_pc", pc, 7);
        end
        reset = 0; step("rst_halt"); reset = 1;
        chk("rst_halt_pc", pc, 0);
        chk("rst_halt_flag", halted, 0);

`ifdef PC_STACK_EN
        jump_to(10);
        instr = {6'b001010, 10'd50}; step("call");
        chk("call_pc", pc, 50); chk("call_nonempty", sp_empty, 0);
        instr = {6'b001011, 10'd0}; step("ret");
        chk("ret_pc", pc, 11); chk("ret_empty", sp_empty, 1);
        for (int i = 1; i <= 5; i++) begin
            instr = {6'b001010, 10'(i * 100)}; step("ncall");
        end
        for (int i = 4; i >= 1; i--) begin
            instr = {6'b001011, 10'd0}; step("nret");
            chk("nret_pc", pc, i * 100 + 1);
        end
        instr = {6'b001011, 10'd0}; step("ret_empty");
        chk("ret_empty_pc", pc, 102);
`endif

        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 31) != 0);
            en       = ($urandom_range(0, 7) != 0);
            instr    = 16'($urandom);
            if (instr[15:10] == 6'b111111 && $urandom_range(0, 3) != 0) instr[15] = 1'b0;
            s_inc    = 1'($urandom);
            wez      = 1'($urandom);
            alu_zero = 1'($urandom);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
